// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: shared I/D-cache miss-service controller with 8-word line fill
// Optional feature: define ARB_RR_EN for round-robin arbitration between the two misses.
module cache_fill_arbiter #(
    parameter int MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icache_miss,
    input  logic [15:0] icache_addr,
    input  logic        dcache_miss,
    input  logic [15:0] dcache_addr,
    input  logic        dcache_wr_req,
    input  logic [15:0] dcache_wr_addr,
    input  logic [15:0] dcache_wr_data,
    output logic        mem_en,
    output logic        mem_wen,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_data_valid,
    output logic [15:0] fill_addr,
    output logic [15:0] fill_data,
    output logic        icache_write_data_array,
    output logic        icache_write_tag_array,
    output logic        dcache_write_data_array,
    output logic        dcache_write_tag_array,
    output logic        dcache_wr_ack,
    output logic        icache_stall,
    output logic        dcache_stall
);
    typedef enum logic [1:0] {IDLE, FILL, WRTAG} state_t;

    // The return path is a simple counter, so the latency only needs range-checking.
    if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_lat_chk
        $error("MEM_LAT must be within 1..8");
    end

    state_t      state_q, state_d;
    logic [15:0] line_q, line_d;
    logic        own_d_q, own_d_d;
    logic [3:0]  issue_q, issue_d;
    logic [3:0]  recv_q, recv_d;
    logic        pick_d;
    logic [15:0] miss_addr;

`ifdef ARB_RR_EN
    logic last_q, last_d;
    // Tie goes to the requester that did not own the previous fill; last_q starts at D so I wins first.
    assign pick_d = dcache_miss & ~(icache_miss & last_q);
    // Round-robin history register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end
`else
    assign pick_d = dcache_miss;
`endif

    assign miss_addr    = pick_d ? dcache_addr : icache_addr;
    assign fill_addr    = line_q | {12'h000, recv_q[2:0], 1'b0};
    assign fill_data    = mem_rdata;
    assign icache_stall = icache_miss;
    assign dcache_stall = dcache_miss | (dcache_wr_req & ~dcache_wr_ack);

    // State, latched line/owner and fill counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            line_q  <= '0;
            own_d_q <= 1'b0;
            issue_q <= '0;
            recv_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            own_d_q <= own_d_d;
            issue_q <= issue_d;
            recv_q  <= recv_d;
        end
    end

    // Arbitration, read issue, word steering and metadata write.
    always_comb begin
        state_d                 = state_q;
        line_d                  = line_q;
        own_d_d                 = own_d_q;
        issue_d                 = issue_q;
        recv_d                  = recv_q;
        mem_en                  = 1'b0;
        mem_wen                 = 1'b0;
        mem_addr                = '0;
        mem_wdata               = '0;
        dcache_wr_ack           = 1'b0;
        icache_write_data_array = 1'b0;
        icache_write_tag_array  = 1'b0;
        dcache_write_data_array = 1'b0;
        dcache_write_tag_array  = 1'b0;
`ifdef ARB_RR_EN
        last_d                  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (rst_n && dcache_wr_req) begin
                    mem_en        = 1'b1;
                    mem_wen       = 1'b1;
                    mem_addr      = dcache_wr_addr;
                    mem_wdata     = dcache_wr_data;
                    dcache_wr_ack = 1'b1;
                end else if (rst_n && (dcache_miss || icache_miss)) begin
                    line_d  = miss_addr & 16'hFFF0;
                    own_d_d = pick_d;
                    issue_d = '0;
                    recv_d  = '0;
                    state_d = FILL;
`ifdef ARB_RR_EN
                    last_d  = pick_d;
`endif
                end
            end
            FILL: begin
                if (issue_q < 4'd8) begin
                    mem_en   = 1'b1;
                    mem_addr = line_q | {12'h000, issue_q[2:0], 1'b0};
                    issue_d  = issue_q + 4'd1;
                end
                if (mem_data_valid) begin
                    icache_write_data_array = ~own_d_q;
                    dcache_write_data_array = own_d_q;
                    recv_d                  = recv_q + 4'd1;
                    state_d                 = (recv_q == 4'd7) ? WRTAG : FILL;
                end
            end
            WRTAG: begin
                icache_write_tag_array = ~own_d_q;
                dcache_write_tag_array = own_d_q;
                state_d                = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb_cache_fill_arbiter: directed self-checking bench for cache_fill_arbiter
module tb_cache_fill_arbiter;
    localparam int MEM_LAT = 4;

    logic        clk, rst_n;
    logic        icache_miss, dcache_miss, dcache_wr_req;
    logic [15:0] icache_addr, dcache_addr, dcache_wr_addr, dcache_wr_data;
    logic        mem_en, mem_wen, mem_data_valid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_addr, fill_data;
    logic        icache_write_data_array, icache_write_tag_array;
    logic        dcache_write_data_array, dcache_write_tag_array;
    logic        dcache_wr_ack, icache_stall, dcache_stall;

    int checks = 0, errors = 0;
    int cyc = 0, gap_lo = -100, gap_len = 0, spur_cyc = -100;
    logic from_q;
    typedef struct { logic [15:0] a; int rdy; } rd_t;
    rd_t q[$];
    logic first_d;
    logic [15:0] first_base, second_base;

    cache_fill_arbiter #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_miss(icache_miss), .icache_addr(icache_addr),
        .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
        .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr), .dcache_wr_data(dcache_wr_data),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .fill_addr(fill_addr), .fill_data(fill_data),
        .icache_write_data_array(icache_write_data_array), .icache_write_tag_array(icache_write_tag_array),
        .dcache_write_data_array(dcache_write_data_array), .dcache_write_tag_array(dcache_write_tag_array),
        .dcache_wr_ack(dcache_wr_ack), .icache_stall(icache_stall), .dcache_stall(dcache_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: fixed latency, in-order returns, optional gap window and one spurious valid.
    always @(posedge clk) begin
        int n;
        if (!rst_n) begin
            q.delete();
            mem_data_valid <= 1'b0;
            mem_rdata      <= '0;
            from_q         <= 1'b0;
        end else begin
            if (mem_data_valid && from_q) q.delete(0);
            if (mem_en && !mem_wen) q.push_back('{mem_addr, cyc + MEM_LAT});
            n = cyc + 1;
            if (n == spur_cyc) begin
                mem_data_valid <= 1'b1;
                mem_rdata      <= 16'hDEAD;
                from_q         <= 1'b0;
            end else if (q.size() > 0 && q[0].rdy <= n && !(n >= gap_lo && n < gap_lo + gap_len)) begin
                mem_data_valid <= 1'b1;
                mem_rdata      <= q[0].a ^ 16'h5A5A;
                from_q         <= 1'b1;
            end else begin
                mem_data_valid <= 1'b0;
                from_q         <= 1'b0;
            end
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks cycles T+1..T+last_k of a fill granted at cycle T; a complete fill then drops the miss.
    task automatic check_fill(input logic own_d, input logic [15:0] base, input int gap, input int last_k);
        for (int k = 1; k <= last_k; k++) begin
            int w, j;
            logic in_gap, dv;
            @(posedge clk); #1;
            @(negedge clk);
            w      = k - 5;
            in_gap = gap > 0 && w > 4 && w <= 4 + gap;
            j      = (gap > 0 && w > 4) ? w - gap : w;
            dv     = !in_gap && j >= 0 && j <= 7;
            chk("rd_en", 32'(mem_en), 32'(k <= 8));
            chk("rd_wen", 32'(mem_wen), 0);
            if (k <= 8) chk("rd_addr", 32'(mem_addr), 32'(base + 16'(2 * (k - 1))));
            chk("d_data_we", 32'(dcache_write_data_array), 32'(own_d & dv));
            chk("i_data_we", 32'(icache_write_data_array), 32'(!own_d & dv));
            if (dv) begin
                chk("fill_addr", 32'(fill_addr), 32'(base + 16'(2 * j)));
                chk("fill_data", 32'(fill_data), 32'((base + 16'(2 * j)) ^ 16'h5A5A));
            end
            if (in_gap) chk("gap_fill_addr", 32'(fill_addr), 32'(base + 16'd10));
            chk("d_tag_we", 32'(dcache_write_tag_array), 32'(own_d && k == 13 + gap));
            chk("i_tag_we", 32'(icache_write_tag_array), 32'(!own_d && k == 13 + gap));
        end
        if (last_k == 13 + gap) begin
            @(posedge clk); #1;
            if (own_d) dcache_miss = 1'b0;
            else icache_miss = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        icache_miss = 1'b0; dcache_miss = 1'b0; dcache_wr_req = 1'b0;
        icache_addr = '0; dcache_addr = '0; dcache_wr_addr = '0; dcache_wr_data = '0;
        // Reset: outputs quiet even with a store pending; stall follows the request.
        repeat (2) @(posedge clk);
        #1 dcache_wr_req = 1'b1; dcache_wr_addr = 16'h1111; dcache_wr_data = 16'h2222;
        @(negedge clk);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_wen", 32'(mem_wen), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_fill_addr", 32'(fill_addr), 0);
        chk("rst_ack", 32'(dcache_wr_ack), 0);
        chk("rst_strobes", 32'({icache_write_data_array, icache_write_tag_array, dcache_write_data_array, dcache_write_tag_array}), 0);
        chk("rst_dstall", 32'(dcache_stall), 1);
        chk("rst_istall", 32'(icache_stall), 0);
        @(posedge clk); #1;
        dcache_wr_req = 1'b0;
        rst_n = 1'b1;
        // I-miss at 0x1234.
        @(posedge clk); #1;
        icache_miss = 1'b1; icache_addr = 16'h1234;
        @(negedge clk);
        chk("imiss_grant_en", 32'(mem_en), 0);
        chk("imiss_istall", 32'(icache_stall), 1);
        check_fill(1'b0, 16'h1230, 0, 13);
        @(negedge clk);
        chk("post_fill_en", 32'(mem_en), 0);
        chk("post_fill_istall", 32'(icache_stall), 0);
        chk("idle_fill_addr", 32'(fill_addr), 32'h1230);
        // Spurious valid in IDLE.
        spur_cyc = cyc + 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("spur_i_we", 32'(icache_write_data_array), 0);
        chk("spur_d_we", 32'(dcache_write_data_array), 0);
        chk("spur_en", 32'(mem_en), 0);
        chk("spur_fill_addr", 32'(fill_addr), 32'h1230);
        @(posedge clk); #1;
        @(negedge clk);
        chk("spur_after_en", 32'(mem_en), 0);
        chk("spur_after_tag", 32'({icache_write_tag_array, dcache_write_tag_array}), 0);
        // Lone store: acked the same cycle, stall already low.
        @(posedge clk); #1;
        dcache_wr_req = 1'b1; dcache_wr_addr = 16'h0100; dcache_wr_data = 16'h1357;
        @(negedge clk);
        chk("st_en", 32'(mem_en), 1);
        chk("st_wen", 32'(mem_wen), 1);
        chk("st_ack", 32'(dcache_wr_ack), 1);
        chk("st_dstall", 32'(dcache_stall), 0);
        chk("st_addr", 32'(mem_addr), 32'h0100);
        chk("st_wdata", 32'(mem_wdata), 32'h1357);
        // Store + D-miss together: store first, D granted next cycle.
        @(posedge clk); #1;
        dcache_wr_addr = 16'h0040; dcache_wr_data = 16'hBEEF;
        dcache_miss = 1'b1; dcache_addr = 16'h2000;
        @(negedge clk);
        chk("std_en", 32'(mem_en), 1);
        chk("std_wen", 32'(mem_wen), 1);
        chk("std_addr", 32'(mem_addr), 32'h0040);
        chk("std_wdata", 32'(mem_wdata), 32'hBEEF);
        chk("std_ack", 32'(dcache_wr_ack), 1);
        chk("std_dstall", 32'(dcache_stall), 1);
        @(posedge clk); #1;
        dcache_wr_req = 1'b0;
        @(negedge clk);
        chk("dgrant_en", 32'(mem_en), 0);
        chk("dgrant_ack", 32'(dcache_wr_ack), 0);
        check_fill(1'b1, 16'h2000, 0, 13);
        // I-miss + D-miss together.
        icache_miss = 1'b1; icache_addr = 16'h567A;
        dcache_miss = 1'b1; dcache_addr = 16'h6789;
`ifdef ARB_RR_EN
        first_d = 1'b0; first_base = 16'h5670; second_base = 16'h6780;
`else
        first_d = 1'b1; first_base = 16'h6780; second_base = 16'h5670;
`endif
        @(negedge clk);
        chk("both_grant_en", 32'(mem_en), 0);
        check_fill(first_d, first_base, 0, 13);
        @(negedge clk);
        chk("second_grant_en", 32'(mem_en), 0);
        chk("second_grant_tag", 32'({icache_write_tag_array, dcache_write_tag_array}), 0);
        check_fill(!first_d, second_base, 0, 13);
        // D-miss with a 2-cycle return gap after word 4.
        dcache_miss = 1'b1; dcache_addr = 16'h3000;
        @(negedge clk);
        gap_lo = cyc + 10; gap_len = 2;
        chk("gap_grant_en", 32'(mem_en), 0);
        check_fill(1'b1, 16'h3000, 2, 15);
        gap_len = 0;
        // Reset mid-fill at word 3, then a full restart from word 0.
        icache_miss = 1'b1; icache_addr = 16'h4444;
        @(negedge clk);
        check_fill(1'b0, 16'h4440, 0, 8);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_strobes", 32'({icache_write_data_array, icache_write_tag_array, dcache_write_data_array, dcache_write_tag_array}), 0);
        chk("abort_en", 32'(mem_en), 0);
        chk("abort_fill_addr", 32'(fill_addr), 0);
        chk("abort_istall", 32'(icache_stall), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_grant_en", 32'(mem_en), 0);
        chk("restart_tag", 32'(icache_write_tag_array), 0);
        check_fill(1'b0, 16'h4440, 0, 13);
        @(negedge clk);
        chk("final_idle_en", 32'(mem_en), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
